// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core.
// TX: frame = start, DATA_BITS data (LSB first), optional parity, STOP_BITS stops.
// RX: 2-flop synchroniser, oversampled mid-bit sampling, false-start rejection,
//     separate parity and framing error flags delivered with a one-cycle strobe.
//
// Handshake: a TX word transfers on every clk edge where tx_valid && tx_ready.
// tx_ready is high only while the TX FSM is idle, and tx_data is only looked at
// in that accept cycle. RX has no backpressure: rx_valid pulses for one cycle
// and rx_data/rx_parity_err/rx_frame_err hold until the next pulse.
module uart_core_param #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   input  logic                 rx,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_busy
);

   localparam int DIV_RAW    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int BIT_CYCLES = DIV * OVERSAMPLE;
   localparam bit PAR_EN     = (PARITY != 0);
   localparam bit PAR_ODD    = (PARITY == 2);
   localparam int CW         = $clog2(BIT_CYCLES);
   localparam int DW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW         = $clog2(OVERSAMPLE);
   localparam int BW         = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // ---------------------------------------------------------------- TX
   state_t                 tx_state, tx_state_d;
   logic [CW-1:0]          tx_cyc, tx_cyc_d;
   logic [BW-1:0]          tx_bit, tx_bit_d;
   logic [DATA_BITS-1:0]   tx_shift, tx_shift_d;
   logic                   tx_par, tx_par_d;
   logic                   tx_d;
   logic                   tx_last;

   assign tx_ready = (tx_state == S_IDLE);
   assign tx_last  = (tx_cyc == CW'(BIT_CYCLES - 1));

   // TX state, bit timer and line register; reset forces the line high at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cyc   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_state_d;
         tx_cyc   <= tx_cyc_d;
         tx_bit   <= tx_bit_d;
         tx_shift <= tx_shift_d;
         tx_par   <= tx_par_d;
         tx       <= tx_d;
      end
   end

   // TX next state; the line value is decoded from the next state so tx is a flop
   always_comb begin
      tx_state_d = tx_state;
      tx_cyc_d   = tx_cyc + CW'(1);
      tx_bit_d   = tx_bit;
      tx_shift_d = tx_shift;
      tx_par_d   = tx_par;
      tx_d       = 1'b1;
      case (tx_state)
         S_IDLE: begin
            tx_cyc_d = '0;
            if (tx_valid) begin
               tx_state_d = S_START;
               tx_shift_d = tx_data;
               tx_par_d   = (^tx_data) ^ PAR_ODD;
               tx_bit_d   = '0;
            end
         end
         S_START: begin
            if (tx_last) begin
               tx_cyc_d   = '0;
               tx_state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_last) begin
               tx_cyc_d = '0;
               if (tx_bit == BW'(DATA_BITS - 1)) begin
                  tx_bit_d   = '0;
                  tx_state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  tx_bit_d   = tx_bit + BW'(1);
                  tx_shift_d = tx_shift >> 1;
               end
            end
         end
         S_PARITY: begin
            if (tx_last) begin
               tx_cyc_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tx_last) begin
               tx_cyc_d = '0;
               if (tx_bit == BW'(STOP_BITS - 1)) begin
                  tx_bit_d   = '0;
                  tx_state_d = S_IDLE;
               end else begin
                  tx_bit_d = tx_bit + BW'(1);
               end
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      case (tx_state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = tx_shift_d[0];
         S_PARITY: tx_d = tx_par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------- RX
   logic                   rx_meta, rx_sync, rx_prev;
   logic                   rx_fall, rx_tick, rx_hit;
   state_t                 rx_state, rx_state_d;
   logic [DW-1:0]          rx_div, rx_div_d;
   logic [SW-1:0]          rx_samp, rx_samp_d;
   logic [BW-1:0]          rx_bit, rx_bit_d;
   logic [DATA_BITS-1:0]   rx_shift, rx_shift_d;
   logic                   rx_perr, rx_perr_d;
   logic                   rx_ferr, rx_ferr_d;
   logic                   rx_done;

   // A falling edge needs a high-then-low history, so a line held low (break,
   // or low at reset release) cannot start a frame until it has gone high.
   assign rx_fall = rx_prev & ~rx_sync;
   assign rx_tick = (rx_div == DW'(DIV - 1));
   assign rx_hit  = rx_tick && (rx_samp == ((rx_state == S_START) ?
                                            SW'(OVERSAMPLE / 2 - 1) :
                                            SW'(OVERSAMPLE - 1)));
   assign rx_busy = (rx_state != S_IDLE);

   // Synchroniser plus one-cycle history for edge detection; cleared low on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b0;
         rx_sync <= 1'b0;
         rx_prev <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // RX state, oversample counters, assembly registers and delivered word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state      <= S_IDLE;
         rx_div        <= '0;
         rx_samp       <= '0;
         rx_bit        <= '0;
         rx_shift      <= '0;
         rx_perr       <= 1'b0;
         rx_ferr       <= 1'b0;
         rx_valid      <= 1'b0;
         rx_data       <= '0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         rx_state <= rx_state_d;
         rx_div   <= rx_div_d;
         rx_samp  <= rx_samp_d;
         rx_bit   <= rx_bit_d;
         rx_shift <= rx_shift_d;
         rx_perr  <= rx_perr_d;
         rx_ferr  <= rx_ferr_d;
         rx_valid <= rx_done;
         if (rx_done) begin
            rx_data       <= rx_shift_d;
            rx_parity_err <= rx_perr_d;
            rx_frame_err  <= rx_ferr_d;
         end
      end
   end

   // RX next state: sample on rx_hit, the mid-bit tick of the current bit
   always_comb begin
      rx_state_d = rx_state;
      rx_div_d   = rx_tick ? '0 : rx_div + DW'(1);
      rx_samp_d  = rx_samp;
      rx_bit_d   = rx_bit;
      rx_shift_d = rx_shift;
      rx_perr_d  = rx_perr;
      rx_ferr_d  = rx_ferr;
      rx_done    = 1'b0;
      if (rx_tick) begin
         rx_samp_d = rx_hit ? '0 : rx_samp + SW'(1);
      end
      case (rx_state)
         S_IDLE: begin
            rx_div_d  = '0;
            rx_samp_d = '0;
            rx_bit_d  = '0;
            if (rx_fall) begin
               rx_state_d = S_START;
               rx_perr_d  = 1'b0;
               rx_ferr_d  = 1'b0;
            end
         end
         S_START: begin
            if (rx_hit) begin
               rx_state_d = rx_sync ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_hit) begin
               rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
               if (rx_bit == BW'(DATA_BITS - 1)) begin
                  rx_bit_d   = '0;
                  rx_state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  rx_bit_d = rx_bit + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (rx_hit) begin
               rx_perr_d  = rx_sync ^ (^rx_shift) ^ PAR_ODD;
               rx_bit_d   = '0;
               rx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (rx_hit) begin
               if (!rx_sync) begin
                  rx_ferr_d = 1'b1;
               end
               if (rx_bit == BW'(STOP_BITS - 1)) begin
                  rx_bit_d   = '0;
                  rx_state_d = S_IDLE;
                  rx_done    = 1'b1;
               end else begin
                  rx_bit_d = rx_bit + BW'(1);
               end
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: four instances (8N1 with switchable loopback,
// 8E1 loopback, 8O1 and 7N2 driven from the bench) sharing clk and rst.
module tb_uart_core_param;

   localparam int CLK_FREQ = 1600000;
   localparam int BAUD     = 100000;
   localparam int OS       = 16;
   localparam int BITC     = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int total = 0;
   int bad   = 0;

   // scoreboard entry: {instance id, frame_err, parity_err, data (zero-extended)}
   logic [11:0] exp_q[$];

   // instance A: 8N1
   logic       tx_valid_a, tx_ready_a, tx_a, rx_a, rx_drv_a, lb_a;
   logic [7:0] tx_data_a, rx_data_a;
   logic       rx_valid_a, rx_perr_a, rx_ferr_a, rx_busy_a;
   // instance E: 8E1 loopback
   logic       tx_valid_e, tx_ready_e, tx_e;
   logic [7:0] tx_data_e, rx_data_e;
   logic       rx_valid_e, rx_perr_e, rx_ferr_e, rx_busy_e;
   // instance O: 8O1
   logic       tx_valid_o, tx_ready_o, tx_o, rx_drv_o;
   logic [7:0] tx_data_o, rx_data_o;
   logic       rx_valid_o, rx_perr_o, rx_ferr_o, rx_busy_o;
   // instance S: 7N2
   logic       tx_valid_s, tx_ready_s, tx_s, rx_drv_s;
   logic [6:0] tx_data_s, rx_data_s;
   logic       rx_valid_s, rx_perr_s, rx_ferr_s, rx_busy_s;

   assign rx_a = lb_a ? tx_a : rx_drv_a;

   uart_core_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .OVERSAMPLE(OS)) u_a (
      .clk(clk), .rst(rst), .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
      .tx(tx_a), .rx(rx_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
      .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a), .rx_busy(rx_busy_a));

   uart_core_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .OVERSAMPLE(OS)) u_e (
      .clk(clk), .rst(rst), .tx_valid(tx_valid_e), .tx_data(tx_data_e), .tx_ready(tx_ready_e),
      .tx(tx_e), .rx(tx_e), .rx_valid(rx_valid_e), .rx_data(rx_data_e),
      .rx_parity_err(rx_perr_e), .rx_frame_err(rx_ferr_e), .rx_busy(rx_busy_e));

   uart_core_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .OVERSAMPLE(OS)) u_o (
      .clk(clk), .rst(rst), .tx_valid(tx_valid_o), .tx_data(tx_data_o), .tx_ready(tx_ready_o),
      .tx(tx_o), .rx(rx_drv_o), .rx_valid(rx_valid_o), .rx_data(rx_data_o),
      .rx_parity_err(rx_perr_o), .rx_frame_err(rx_ferr_o), .rx_busy(rx_busy_o));

   uart_core_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(0),
                     .STOP_BITS(2), .OVERSAMPLE(OS)) u_s (
      .clk(clk), .rst(rst), .tx_valid(tx_valid_s), .tx_data(tx_data_s), .tx_ready(tx_ready_s),
      .tx(tx_s), .rx(rx_drv_s), .rx_valid(rx_valid_s), .rx_data(rx_data_s),
      .rx_parity_err(rx_perr_s), .rx_frame_err(rx_ferr_s), .rx_busy(rx_busy_s));

   // ------------------------------------------------ clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------ scoreboard monitor
   logic [3:0]  mon_v;
   logic [11:0] mon_w [4];
   assign mon_v    = {rx_valid_s, rx_valid_o, rx_valid_e, rx_valid_a};
   assign mon_w[0] = {2'd0, rx_ferr_a, rx_perr_a, rx_data_a};
   assign mon_w[1] = {2'd1, rx_ferr_e, rx_perr_e, rx_data_e};
   assign mon_w[2] = {2'd2, rx_ferr_o, rx_perr_o, rx_data_o};
   assign mon_w[3] = {2'd3, rx_ferr_s, rx_perr_s, 1'b0, rx_data_s};

   always @(negedge clk) begin
      logic [11:0] exp_w;
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (mon_v[i]) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL sb_unexpected inst=%0d got=%h required=none", i, mon_w[i]);
               end else begin
                  exp_w = exp_q.pop_front();
                  if (mon_w[i] !== exp_w) begin
                     bad++;
                     $display("FAIL sb_rx inst=%0d got=%h required=%h", i, mon_w[i], exp_w);
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------ driver tasks
   task automatic set_rx(input int inst, input logic v);
      case (inst)
         0:       rx_drv_a = v;
         2:       rx_drv_o = v;
         default: rx_drv_s = v;
      endcase
   endtask

   task automatic rx_bit(input int inst, input logic v);
      set_rx(inst, v);
      repeat (BITC) @(negedge clk);
   endtask

   task automatic drive_rx(input int inst, input logic [7:0] word, input int nd, input int np,
                           input logic pbit, input logic [1:0] stops, input int ns);
      rx_bit(inst, 1'b0);
      for (int i = 0; i < nd; i++) rx_bit(inst, word[i]);
      if (np != 0) rx_bit(inst, pbit);
      for (int i = 0; i < ns; i++) rx_bit(inst, stops[i]);
      set_rx(inst, 1'b1);
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (exp_q.size() == 0);
   endtask

   // ------------------------------------------------ tests
   task automatic test_reset;
      tx_valid_a = 0; tx_data_a = 0; rx_drv_a = 1; lb_a = 0;
      tx_valid_e = 0; tx_data_e = 0;
      tx_valid_o = 0; tx_data_o = 0; rx_drv_o = 1;
      tx_valid_s = 0; tx_data_s = 0; rx_drv_s = 1;
      rst = 1;
      repeat (3) @(negedge clk);
      total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b required=1", tx_a); end
      total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b required=1", tx_ready_a); end
      total++; if (rx_valid_a !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b required=0", rx_valid_a); end
      total++; if (rx_data_a !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h required=00", rx_data_a); end
      total++; if ({rx_perr_a, rx_ferr_a} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b required=00", {rx_perr_a, rx_ferr_a}); end
      total++; if (rx_busy_a !== 1'b0) begin bad++; $display("FAIL rst_rx_busy got=%b required=0", rx_busy_a); end
      total++; if (tx_e !== 1'b1) begin bad++; $display("FAIL rst_tx_e got=%b required=1", tx_e); end
      rst = 0;
      repeat (10) @(negedge clk);
      total++; if ({tx_ready_a, tx_a, rx_busy_a} !== 3'b110) begin bad++; $display("FAIL post_rst_idle got=%b required=110", {tx_ready_a, tx_a, rx_busy_a}); end
   endtask

   // 8N1 0xA5 waveform, tx_data ignored while busy, back-to-back 0x3C, looped back to RX
   task automatic test_tx_8n1;
      logic [9:0] fr1, fr2;
      logic exp_tx, exp_rdy;
      bit ok;
      fr1 = {1'b1, 8'hA5, 1'b0};
      fr2 = {1'b1, 8'h3C, 1'b0};
      lb_a = 1;
      repeat (5) @(negedge clk);
      total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL tx_ready_pre got=%b required=1", tx_ready_a); end
      tx_valid_a = 1; tx_data_a = 8'hA5;
      exp_q.push_back({2'd0, 1'b0, 1'b0, 8'hA5});
      exp_q.push_back({2'd0, 1'b0, 1'b0, 8'h3C});
      for (int k = 1; k <= 322; k++) begin
         @(negedge clk);
         if (k <= 160) begin exp_tx = fr1[(k-1)/BITC]; exp_rdy = 0; end
         else if (k == 161) begin exp_tx = 1; exp_rdy = 1; end
         else if (k <= 321) begin exp_tx = fr2[(k-162)/BITC]; exp_rdy = 0; end
         else begin exp_tx = 1; exp_rdy = 1; end
         total++; if (tx_a !== exp_tx) begin bad++; $display("FAIL tx_line cyc=%0d got=%b required=%b", k, tx_a, exp_tx); end
         total++; if (tx_ready_a !== exp_rdy) begin bad++; $display("FAIL tx_ready cyc=%0d got=%b required=%b", k, tx_ready_a, exp_rdy); end
         if (k < 161) tx_data_a = 8'($urandom_range(0, 255));
         else if (k == 161) tx_data_a = 8'h3C;
         else tx_valid_a = 0;
      end
      wait_drain(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL tx_8n1_drain got=%0d required=0", exp_q.size()); end
   endtask

   // 8E1 loopback 0x07: parity bit is 1
   task automatic test_loopback_8e1;
      logic [10:0] fr;
      logic exp_tx;
      bit ok;
      fr = {1'b1, ^8'h07, 8'h07, 1'b0};
      @(negedge clk);
      tx_valid_e = 1; tx_data_e = 8'h07;
      exp_q.push_back({2'd1, 1'b0, 1'b0, 8'h07});
      for (int k = 1; k <= 177; k++) begin
         @(negedge clk);
         tx_valid_e = 0;
         exp_tx = (k <= 176) ? fr[(k-1)/BITC] : 1'b1;
         total++; if (tx_e !== exp_tx) begin bad++; $display("FAIL tx_8e1 cyc=%0d got=%b required=%b", k, tx_e, exp_tx); end
      end
      total++; if (tx_ready_e !== 1'b1) begin bad++; $display("FAIL tx_ready_8e1 got=%b required=1", tx_ready_e); end
      wait_drain(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL e1_drain got=%0d required=0", exp_q.size()); end
   endtask

   // 8O1 0x3C with good parity, then with bad parity
   task automatic test_parity_8o1;
      logic good_p;
      bit ok;
      good_p = ~(^8'h3C);
      exp_q.push_back({2'd2, 1'b0, (1'b1 != good_p), 8'h3C});
      drive_rx(2, 8'h3C, 8, 1, 1'b1, 2'b11, 1);
      exp_q.push_back({2'd2, 1'b0, (1'b0 != good_p), 8'h3C});
      drive_rx(2, 8'h3C, 8, 1, 1'b0, 2'b11, 1);
      wait_drain(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL o1_drain got=%0d required=0", exp_q.size()); end
   endtask

   // 7N2 good 0x2A, then 0x55 with the second stop bit low
   task automatic test_frame_7n2;
      bit ok;
      exp_q.push_back({2'd3, 1'b0, 1'b0, 8'h2A});
      drive_rx(3, 8'h2A, 7, 0, 1'b0, 2'b11, 2);
      exp_q.push_back({2'd3, 1'b1, 1'b0, 8'h55});
      drive_rx(3, 8'h55, 7, 0, 1'b0, 2'b01, 2);
      wait_drain(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL n2_drain got=%0d required=0", exp_q.size()); end
   endtask

   // 4-cycle glitch: rx_busy pulses, nothing delivered, then 0x81 arrives
   task automatic test_false_start;
      int busy_n = 0;
      bit ok;
      lb_a = 0; rx_drv_a = 1;
      repeat (20) @(negedge clk);
      rx_drv_a = 0;
      repeat (4) @(negedge clk);
      rx_drv_a = 1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (rx_busy_a) busy_n++;
      end
      total++; if (busy_n < 6 || busy_n > 10) begin bad++; $display("FAIL fs_busy_cycles got=%0d required=6..10", busy_n); end
      total++; if ({rx_ferr_a, rx_perr_a, rx_data_a} !== {2'b00, 8'h3C}) begin bad++; $display("FAIL fs_hold got=%h required=03c", {rx_ferr_a, rx_perr_a, rx_data_a}); end
      exp_q.push_back({2'd0, 1'b0, 1'b0, 8'h81});
      drive_rx(0, 8'h81, 8, 0, 1'b0, 2'b11, 1);
      wait_drain(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL fs_drain got=%0d required=0", exp_q.size()); end
   endtask

   // break: one frame of zeros with framing error, no re-arm while low
   task automatic test_break;
      int busy_n = 0;
      bit ok;
      exp_q.push_back({2'd0, 1'b1, 1'b0, 8'h00});
      rx_drv_a = 0;
      wait_drain(300, ok);
      total++; if (!ok) begin bad++; $display("FAIL brk_drain got=%0d required=0", exp_q.size()); end
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (rx_busy_a) busy_n++;
      end
      total++; if (busy_n != 0) begin bad++; $display("FAIL brk_rearm got=%0d required=0", busy_n); end
      rx_drv_a = 1;
      repeat (20) @(negedge clk);
      exp_q.push_back({2'd0, 1'b0, 1'b0, 8'h42});
      drive_rx(0, 8'h42, 8, 0, 1'b0, 2'b11, 1);
      wait_drain(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL brk_after got=%0d required=0", exp_q.size()); end
   endtask

   // reset during TX data bit 3 (RX mid-data via loopback), then 0x5A both ways
   task automatic test_reset_midframe;
      bit ok;
      lb_a = 1;
      repeat (20) @(negedge clk);
      tx_valid_a = 1; tx_data_a = 8'hC3;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         tx_valid_a = 0;
      end
      total++; if (rx_busy_a !== 1'b1) begin bad++; $display("FAIL mid_rx_busy got=%b required=1", rx_busy_a); end
      rst = 1;
      #1;
      total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL mid_rst_tx got=%b required=1", tx_a); end
      total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b required=1", tx_ready_a); end
      total++; if ({rx_busy_a, rx_valid_a} !== 2'b00) begin bad++; $display("FAIL mid_rst_rx got=%b required=00", {rx_busy_a, rx_valid_a}); end
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (200) @(negedge clk);
      total++; if (rx_data_a !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h required=00", rx_data_a); end
      total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL mid_ready_back got=%b required=1", tx_ready_a); end
      tx_valid_a = 1; tx_data_a = 8'h5A;
      exp_q.push_back({2'd0, 1'b0, 1'b0, 8'h5A});
      @(negedge clk);
      tx_valid_a = 0;
      wait_drain(400, ok);
      total++; if (!ok) begin bad++; $display("FAIL mid_5a_drain got=%0d required=0", exp_q.size()); end
      repeat (30) @(negedge clk);
      total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL mid_5a_ready got=%b required=1", tx_ready_a); end
   endtask

   initial begin
      test_reset();
      test_tx_8n1();
      test_loopback_8e1();
      test_parity_8o1();
      test_frame_7n2();
      test_false_start();
      test_break();
      test_reset_midframe();
      repeat (20) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART core, the next generation of the team's fixed 8-bit UART driver. It supports configurable data width, parity mode (none/even/odd), 1 or 2 stop bits and an oversampled receiver with mid-bit sampling, false-start rejection and separate parity/framing error flags. The transmit side uses a valid/ready handshake and the receive side a one-cycle valid strobe, so the core sits directly between a register block or FIFO and the pads.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, RX samples per bit; even, >= 8

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tx_valid  in  1  transmit request
tx_data  in  DATA_BITS  word to send
tx_ready  out  1  TX idle, can accept a word
tx  out  1  serial output, idles high
rx  in  1  serial input (asynchronous)
rx_valid  out  1  one-cycle strobe: received word available
rx_data  out  DATA_BITS  last received word
rx_parity_err  out  1  parity mismatch on last word
rx_frame_err  out  1  stop bit(s) low on last word
rx_busy  out  1  RX frame in progress

Behaviour:
- Derived constants: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), minimum 1; BIT_CYCLES = DIV*OVERSAMPLE; NBITS = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- Reset (async): tx=1, tx_ready=1, rx_valid=0, rx_data=0, both error flags 0, rx_busy=0, both FSMs in IDLE, all counters 0. Reset mid-frame aborts the frame and drives tx high immediately.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - Accept on tx_valid && tx_ready (cycle N): latch tx_data, compute parity from the latched word.
  - tx_ready is low from N+1 to N+NBITS*BIT_CYCLES inclusive, high again at N+1+NBITS*BIT_CYCLES.
  - tx goes low at N+1. Each bit holds for exactly BIT_CYCLES clocks, timed by a private counter cleared at accept.
  - Data is sent LSB first. Parity bit: even = XOR of data; odd = its inverse. Stop bit(s) are 1.
  - Back-to-back: a word accepted in the cycle tx_ready returns high starts the next frame with no extra idle bit.
  - tx_data is ignored while tx_ready=0.
- RX input: rx passes through a 2-flop synchroniser. All references below use the synchronised signal (adds 2 cycles of latency).
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - Oversample tick every DIV clocks; the RX divider is cleared on the falling edge detected in IDLE.
  - rx_busy is high in all states except IDLE.
  - START: sample at tick OVERSAMPLE/2. If high, it is a false start: return to IDLE with no rx_valid and no flags changed.
  - Each subsequent bit is sampled every OVERSAMPLE ticks, at its centre. Data is assembled LSB first.
  - PARITY: compare the received bit with the parity computed over the received data; mismatch sets the parity error.
  - STOP: every stop bit is sampled at its centre; any zero sets the framing error.
  - After the last stop sample: next cycle rx_valid=1 for exactly one cycle. rx_data, rx_parity_err and rx_frame_err update in that same cycle and hold until the next rx_valid. The FSM returns to IDLE in the same cycle, so a start bit immediately after the stop-bit centre is caught.
  - The word is delivered even when an error flag is set.
  - No flow control on RX: an unread word is overwritten by the next rx_valid.
- A break condition (rx held low) yields a frame with data 0 and rx_frame_err=1. The FSM then waits in IDLE for rx to return high before arming edge detection again.
- TX and RX are independent and may run simultaneously; loopback (rx tied to tx) must work.

Test Plan:
Sim params throughout: CLK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16, giving DIV=1 and BIT_CYCLES=16.
- 8N1, send 0xA5 at cycle N -> tx low at N+1..N+16, then data bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high. tx_ready low for 160 cycles and high at N+161.
- Loopback 8E1, send 0x07 -> parity bit on tx = 1. Exactly one rx_valid with rx_data=0x07, rx_parity_err=0, rx_frame_err=0.
- 8O1, bench drives 0x3C with parity bit 1 (odd requires 1; drive 0 on the next frame) -> first frame no error; second frame rx_parity_err=1, rx_data=0x3C.
- 7N2, bench drives 0x55 with the second stop bit low -> rx_valid with rx_data=0x55, rx_frame_err=1.
- False start: rx pulsed low for 4 cycles -> rx_busy pulses, no rx_valid, flags unchanged. A subsequent valid 0x81 frame is received correctly.
- Assert rst during TX data bit 3 and during RX data -> tx=1 and tx_ready=1 immediately. No rx_valid. A following 0x5A frame passes in both directions.
